// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Also holds the register-match helper used by forwarding and load-use detection.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    // Bubble the datapath loads into a flushed pipeline register.
    localparam logic [31:0] NOP = 32'h0000_0020;

    localparam int NUM_OPS = 2;

    // True when a writing stage targets src; r0 never counts as a producer.
    function automatic logic reg_hit(logic we, logic [4:0] wa, logic [4:0] src);
        return we && (wa != 5'd0) && (wa == src);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> controller bundle: hazard inputs from ID/EX/MEM/WB, control outputs back.
// The datapath side is master, pipe_ctrl is slave.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
    import pipe_ctrl_pkg::*;

    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_wraddr;
    logic       ex_regwrite, ex_memtoreg, ex_branch_taken;
    logic       mem_regwrite, wb_regwrite;
    logic [4:0] mem_wraddr, wb_wraddr;
    logic       mem_req, dmem_ready;

    logic       pc_en;
    logic       ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic       exmem_stall, exmem_flush, memwb_stall, memwb_flush;
    fwd_sel_t   fwd_a, fwd_b;
    logic       bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_wraddr,
               ex_regwrite, ex_memtoreg, ex_branch_taken, mem_regwrite, wb_regwrite,
               mem_wraddr, wb_wraddr, mem_req, dmem_ready,
        input  pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               exmem_flush, memwb_stall, memwb_flush, fwd_a, fwd_b, bus_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_wraddr,
               ex_regwrite, ex_memtoreg, ex_branch_taken, mem_regwrite, wb_regwrite,
               mem_wraddr, wb_wraddr, mem_req, dmem_ready,
        output pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               exmem_flush, memwb_stall, memwb_flush, fwd_a, fwd_b, bus_err,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_fwd_unit.sv
// One EX operand's bypass select; the MEM result is younger so it wins over WB.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_wraddr,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_wraddr,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_hit(mem_regwrite, mem_wraddr, src))
            sel = FWD_MEM;
        else if (reg_hit(wb_regwrite, wb_wraddr, src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch/load-use
// stall-flush generation, operand forwarding and saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic mem_stall, load_use;
    logic pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, memwb_flush;

    assign mem_stall = bus.mem_req && !bus.dmem_ready;
    assign load_use  = bus.ex_memtoreg &&
                       ((bus.id_uses_rs && reg_hit(bus.ex_regwrite, bus.ex_wraddr, bus.id_rs)) ||
                        (bus.id_uses_rt && reg_hit(bus.ex_regwrite, bus.ex_wraddr, bus.id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // A taken branch seen during a memory stall needs no storage: EX is frozen,
    // so the datapath keeps presenting it until the stall clears.
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        pc_en       = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        unique case (state_q)
            ST_RUN:      if (mem_stall) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (bus.dmem_ready)          state_d = ST_RUN;
                else if (wait_q == WAIT_LAST) state_d = ST_ERR;
                else                         wait_d  = wait_q + WAIT_W'(1);
            end
            ST_ERR:      state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        if (state_q == ST_ERR) begin
            // Kill the faulting access and let the front end keep flowing.
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en       = 1'b0;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((ifid_flush || idex_flush) && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    logic     [NUM_OPS-1:0][4:0] ex_src;
    fwd_sel_t [NUM_OPS-1:0]      fwd_sel;

    assign ex_src = {bus.ex_rt, bus.ex_rs};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        pipe_fwd_unit u_fwd (
            .src          (ex_src[i]),
            .mem_regwrite (bus.mem_regwrite),
            .mem_wraddr   (bus.mem_wraddr),
            .wb_regwrite  (bus.wb_regwrite),
            .wb_wraddr    (bus.wb_wraddr),
            .sel          (fwd_sel[i])
        );
    end

    assign bus.fwd_a       = fwd_sel[0];
    assign bus.fwd_b       = fwd_sel[1];
    assign bus.pc_en       = pc_en;
    assign bus.ifid_stall  = ifid_stall;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_stall  = idex_stall;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_stall = exmem_stall;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_stall = 1'b0;
    assign bus.memwb_flush = memwb_flush;
    assign bus.bus_err     = (state_q == ST_ERR);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Random + directed bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [9:0] C_ERR  = 10'b1000001011;
    localparam logic [9:0] C_MEM  = 10'b0101010010;
    localparam logic [9:0] C_BR   = 10'b1010100000;
    localparam logic [9:0] C_LU   = 10'b0100100000;
    localparam logic [9:0] C_NORM = 10'b1000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // model: outstanding wait, cycles waited so far, pending error cycle, counters
    bit m_wait, m_err;
    int m_waited, m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, act, exp);
        end
    endtask

    function automatic int fwd_of(input logic [4:0] src);
        if (bus.mem_regwrite && bus.mem_wraddr != 0 && bus.mem_wraddr == src) return 2;
        if (bus.wb_regwrite && bus.wb_wraddr != 0 && bus.wb_wraddr == src) return 1;
        return 0;
    endfunction

    function automatic logic [9:0] exp_ctl();
        bit lu;
        lu = bus.ex_memtoreg && bus.ex_regwrite && bus.ex_wraddr != 0 &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_wraddr) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_wraddr));
        if (m_err) return C_ERR;
        if (bus.mem_req && !bus.dmem_ready) return C_MEM;
        if (bus.ex_branch_taken) return C_BR;
        if (lu) return C_LU;
        return C_NORM;
    endfunction

    function automatic int exp_state();
        if (m_err) return int'(ST_ERR);
        if (m_wait) return int'(ST_MEM_WAIT);
        return int'(ST_RUN);
    endfunction

    // Called just after a rising edge with inputs already applied.
    task automatic step(input string tag);
        logic [9:0] e, a;
        #1;
        e = exp_ctl();
        a = {bus.pc_en, bus.ifid_stall, bus.ifid_flush, bus.idex_stall, bus.idex_flush,
             bus.exmem_stall, bus.exmem_flush, bus.memwb_stall, bus.memwb_flush, bus.bus_err};
        chk({tag, "_ctl"}, a, e);
        chk({tag, "_fwda"}, bus.fwd_a, fwd_of(bus.ex_rs));
        chk({tag, "_fwdb"}, bus.fwd_b, fwd_of(bus.ex_rt));
        chk({tag, "_scnt"}, bus.stall_cnt, m_stall);
        chk({tag, "_fcnt"}, bus.flush_cnt, m_flush);
        chk({tag, "_state"}, dut.state_q, exp_state());
        @(posedge clk);
        if (!e[9] && m_stall < CMAX) m_stall++;
        if ((e[7] || e[5]) && m_flush < CMAX) m_flush++;
        if (m_err) m_err = 0;
        else if (m_wait) begin
            if (bus.dmem_ready) m_wait = 0;
            else begin
                m_waited++;
                if (m_waited == TO) begin m_err = 1; m_wait = 0; end
            end
        end else if (bus.mem_req && !bus.dmem_ready) m_wait = 1;
        if (!m_wait) m_waited = 0;
        #1;
    endtask

    task automatic clr();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_wraddr = 0;
        bus.ex_regwrite = 0; bus.ex_memtoreg = 0; bus.ex_branch_taken = 0;
        bus.mem_regwrite = 0; bus.mem_wraddr = 0; bus.wb_regwrite = 0; bus.wb_wraddr = 0;
        bus.mem_req = 0; bus.dmem_ready = 0;
    endtask

    task automatic rnd_in();
        bus.id_rs = 5'($urandom_range(0, 3));
        bus.id_rt = 5'($urandom_range(0, 3));
        bus.id_uses_rs = 1'($urandom_range(0, 1));
        bus.id_uses_rt = 1'($urandom_range(0, 1));
        bus.ex_rs = 5'($urandom_range(0, 3));
        bus.ex_rt = 5'($urandom_range(0, 3));
        bus.ex_wraddr = 5'($urandom_range(0, 3));
        bus.ex_regwrite = 1'($urandom_range(0, 1));
        bus.ex_memtoreg = 1'($urandom_range(0, 1));
        bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
        bus.mem_regwrite = 1'($urandom_range(0, 1));
        bus.mem_wraddr = 5'($urandom_range(0, 3));
        bus.wb_regwrite = 1'($urandom_range(0, 1));
        bus.wb_wraddr = 5'($urandom_range(0, 3));
        bus.mem_req = ($urandom_range(0, 2) == 0);
        bus.dmem_ready = ($urandom_range(0, 9) < 3);
    endtask

    // Reset applied between edges; state and counters must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_scnt", bus.stall_cnt, 0);
        chk("rst_fcnt", bus.flush_cnt, 0);
        chk("rst_berr", bus.bus_err, 0);
        chk("rst_state", dut.state_q, int'(ST_RUN));
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clr();
        do_reset();
        step("idle");

        // single load-use bubble
        bus.ex_memtoreg = 1; bus.ex_regwrite = 1; bus.ex_wraddr = 8;
        bus.id_rs = 8; bus.id_uses_rs = 1;
        step("lu");
        chk("lu_stall_cnt", bus.stall_cnt, 1);
        clr();
        step("lu_after");

        // three wait cycles then completion
        do_reset();
        bus.mem_req = 1; bus.dmem_ready = 0;
        repeat (3) step("mwait");
        bus.dmem_ready = 1;
        step("mready");
        chk("mwait_stall_cnt", bus.stall_cnt, 3);
        clr();
        step("mdone");

        // timeout into ERR, single-cycle bus_err
        do_reset();
        bus.mem_req = 1; bus.dmem_ready = 0;
        repeat (TO + 1) step("tout");
        chk("tout_berr", bus.bus_err, 1);
        chk("tout_exmem_flush", bus.exmem_flush, 1);
        step("terr");
        clr();
        chk("tout_berr_clr", bus.bus_err, 0);
        step("trun");

        // branch beats load-use
        do_reset();
        bus.ex_memtoreg = 1; bus.ex_regwrite = 1; bus.ex_wraddr = 8;
        bus.id_rs = 8; bus.id_uses_rs = 1; bus.ex_branch_taken = 1;
        step("br_lu");
        chk("br_flush_cnt", bus.flush_cnt, 1);
        clr();

        // forwarding priority and r0
        bus.ex_rs = 5; bus.mem_wraddr = 5; bus.wb_wraddr = 5;
        bus.mem_regwrite = 1; bus.wb_regwrite = 1;
        #1 chk("fwd_mem_pri", bus.fwd_a, 2'b10);
        step("fwd1");
        bus.ex_rs = 0; bus.mem_wraddr = 0;
        #1 chk("fwd_r0", bus.fwd_a, 2'b00);
        step("fwd2");
        bus.ex_rt = 5; bus.mem_wraddr = 7;
        #1 chk("fwd_wb", bus.fwd_b, 2'b01);
        step("fwd3");
        clr();

        // reset abandons a wait; first cycle after release acts on live inputs
        bus.mem_req = 1; bus.dmem_ready = 0;
        repeat (3) step("rw");
        do_reset();
        step("rw_live");
        clr();
        step("rw_idle");

        for (int i = 0; i < 3000; i++) begin
            rnd_in();
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
